cache_kv_controller: RTL and testbench



---
 rtl/cache_kv_controller_if.sv | 43 ++++
 rtl/cache_kv_controller.sv | 198 +++++++++++++++++++
 tb/tb_cache_kv_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cache_kv_controller_if.sv
// Shared types and the request/response bundle between the OBI cache
// interface (master side) and the key-value controller (slave side).

package if_types_pkg;
    localparam int KEY_WIDTH   = 32;
    localparam int VALUE_WIDTH = 64;
endpackage

package ctrl_types_pkg;
    // 3-bit encoding so that illegal (non-NOOP, unknown) ops are representable.
    typedef enum logic [2:0] {
        OP_NOOP   = 3'd0,
        OP_READ   = 3'd1,
        OP_UPSERT = 3'd2,
        OP_DELETE = 3'd3
    } operation_e;
endpackage

interface cache_kv_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
    parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) ();
    ctrl_types_pkg::operation_e operation_in;
    logic [KEY_WIDTH-1:0]       key_in;
    logic [VALUE_WIDTH-1:0]     value_in;
    logic                       ready_out;
    logic                       op_succ_out;
    logic [VALUE_WIDTH-1:0]     value_out;
    logic                       busy_out;
    logic [CNT_WIDTH-1:0]       count_out;

    modport master (
        output operation_in, key_in, value_in,
        input  ready_out, op_succ_out, value_out, busy_out, count_out
    );

    modport slave (
        input  operation_in, key_in, value_in,
        output ready_out, op_succ_out, value_out, busy_out, count_out
    );
endinterface

// File: rtl/cache_kv_controller.sv
// Key-value store controller: executes READ/UPSERT/DELETE requests against a
// small fully-associative table, one operation in flight at a time.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a non-NOOP op; inputs sampled only here
// ST_LOOKUP  | match latched key against valid entries, find free slot
// ST_EXECUTE | register result status/value and perform the table write
// ST_RESPOND | ready_out pulse; result held on op_succ_out/value_out

module cache_kv_controller
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
    parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    cache_kv_if.slave  kv
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   ready_c, busy_c;

    operation_e             req_op_q;
    logic [KEY_WIDTH-1:0]   req_key_q;
    logic [VALUE_WIDTH-1:0] req_val_q;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [KEY_WIDTH-1:0]   key_mem [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] val_mem [NUM_ENTRIES];

    logic             hit_c, free_found_c, full_c;
    logic [IDX_W-1:0] hit_idx_c, free_idx_c;
    logic             hit_q, full_q;
    logic [IDX_W-1:0] hit_idx_q, free_idx_q;

    logic                   exec_c;
    logic                   wr_en_c, set_valid_c, clr_valid_c;
    logic                   cnt_inc_c, cnt_dec_c;
    logic [IDX_W-1:0]       wr_idx_c;
    logic                   succ_c;
    logic [VALUE_WIDTH-1:0] rdata_c;

    logic                   succ_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic [CNT_WIDTH-1:0]   count_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state and status outputs
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        busy_c  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (kv.operation_in != OP_NOOP) state_d = ST_LOOKUP;
            end
            ST_LOOKUP:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = ST_RESPOND;
            ST_RESPOND: begin
                ready_c = 1'b1;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Associative match on the latched key plus lowest free slot search
    always_comb begin
        hit_c        = 1'b0;
        hit_idx_c    = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && (key_mem[i] == req_key_q) && !hit_c) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
        full_c = &valid_q;
    end

    // Decode what the EXECUTE cycle does to the table and the result
    always_comb begin
        exec_c      = (state_q == ST_EXECUTE);
        wr_en_c     = 1'b0;
        set_valid_c = 1'b0;
        clr_valid_c = 1'b0;
        cnt_inc_c   = 1'b0;
        cnt_dec_c   = 1'b0;
        wr_idx_c    = hit_idx_q;
        succ_c      = 1'b0;
        rdata_c     = '0;
        case (req_op_q)
            OP_READ: begin
                if (hit_q) begin
                    succ_c  = 1'b1;
                    rdata_c = val_mem[hit_idx_q];
                end
            end
            OP_UPSERT: begin
                if (hit_q) begin
                    wr_en_c = 1'b1;
                    succ_c  = 1'b1;
                end else if (!full_q) begin
                    wr_en_c     = 1'b1;
                    wr_idx_c    = free_idx_q;
                    set_valid_c = 1'b1;
                    cnt_inc_c   = 1'b1;
                    succ_c      = 1'b1;
                end
            end
            OP_DELETE: begin
                if (hit_q) begin
                    clr_valid_c = 1'b1;
                    cnt_dec_c   = 1'b1;
                    succ_c      = 1'b1;
                    rdata_c     = val_mem[hit_idx_q];
                end
            end
            default: ;
        endcase
    end

    // Request latch, lookup results, valid bits, occupancy and result regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op_q   <= OP_NOOP;
            req_key_q  <= '0;
            req_val_q  <= '0;
            hit_q      <= 1'b0;
            full_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            succ_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && kv.operation_in != OP_NOOP) begin
                req_op_q  <= kv.operation_in;
                req_key_q <= kv.key_in;
                req_val_q <= kv.value_in;
            end
            if (state_q == ST_LOOKUP) begin
                hit_q      <= hit_c;
                hit_idx_q  <= hit_idx_c;
                free_idx_q <= free_idx_c;
                full_q     <= full_c;
            end
            if (exec_c) begin
                succ_q  <= succ_c;
                rdata_q <= rdata_c;
                if (set_valid_c) valid_q[wr_idx_c]  <= 1'b1;
                if (clr_valid_c) valid_q[hit_idx_q] <= 1'b0;
                if (cnt_inc_c)   count_q <= count_q + CNT_WIDTH'(1);
                if (cnt_dec_c)   count_q <= count_q - CNT_WIDTH'(1);
            end
        end
    end

    // Entry storage; validity alone decides whether contents matter
    always_ff @(posedge clk) begin
        if (exec_c && wr_en_c) begin
            key_mem[wr_idx_c] <= req_key_q;
            val_mem[wr_idx_c] <= req_val_q;
        end
    end

    assign kv.ready_out   = ready_c;
    assign kv.busy_out    = busy_c;
    assign kv.op_succ_out = succ_q;
    assign kv.value_out   = rdata_q;
    assign kv.count_out   = count_q;

endmodule

// File: tb/tb_cache_kv_controller.sv
// Self-checking bench for cache_kv_controller with a 4-entry table.

module tb_cache_kv_controller;
    import ctrl_types_pkg::*;

    localparam int NE = 4;
    localparam int KW = 32;
    localparam int VW = 64;
    localparam int CW = $clog2(NE + 1);

    typedef struct {
        logic          succ;
        logic [VW-1:0] val;
        int            cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    cache_kv_if #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_WIDTH(CW)) kv ();

    cache_kv_controller #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kv    (kv)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ready_pulses = 0;

    exp_t          sb_q[$];
    logic [VW-1:0] mdl [logic [KW-1:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle with ready high, sampled away from the active edge
    always @(negedge clk) if (kv.ready_out === 1'b1) ready_pulses++;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compute the expected result from the reference model and queue it
    task automatic predict(input operation_e op, input logic [KW-1:0] key, input logic [VW-1:0] val);
        exp_t e;
        e.succ = 1'b0;
        e.val  = '0;
        case (op)
            OP_READ: if (mdl.exists(key)) begin
                e.succ = 1'b1;
                e.val  = mdl[key];
            end
            OP_UPSERT: if (mdl.exists(key) || mdl.num() < NE) begin
                mdl[key] = val;
                e.succ   = 1'b1;
            end
            OP_DELETE: if (mdl.exists(key)) begin
                e.val  = mdl[key];
                e.succ = 1'b1;
                mdl.delete(key);
            end
            default: ;
        endcase
        e.cnt = mdl.num();
        sb_q.push_back(e);
    endtask

    // Issue one op, optionally poke a new op while busy, then check the response
    task automatic run_op(input string tag, input operation_e op, input logic [KW-1:0] key,
                          input logic [VW-1:0] val, input bit poke_busy);
        int   cyc;
        int   pulses0;
        exp_t e;
        pulses0 = ready_pulses;
        @(negedge clk);
        kv.operation_in = op;
        kv.key_in       = key;
        kv.value_in     = val;
        predict(op, key, val);
        @(posedge clk);
        #1;
        if (poke_busy) begin
            kv.operation_in = OP_UPSERT;
            kv.key_in       = 32'h99;
            kv.value_in     = 64'h99;
        end else begin
            kv.operation_in = OP_NOOP;
        end
        check_val({tag, "_busy"}, 64'(kv.busy_out), 64'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (kv.ready_out !== 1'b1 && cyc < 20);
        kv.operation_in = OP_NOOP;
        check_val({tag, "_latency"}, 64'(cyc), 64'd3);
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_succ"},  64'(kv.op_succ_out), 64'(e.succ));
            check_val({tag, "_value"}, kv.value_out,        e.val);
            check_val({tag, "_count"}, 64'(kv.count_out),   64'(e.cnt));
        end
        @(negedge clk);
        check_val({tag, "_ready_1cyc"}, 64'(kv.ready_out), 64'd0);
        check_val({tag, "_idle"},       64'(kv.busy_out),  64'd0);
        check_val({tag, "_pulses"},     64'(ready_pulses - pulses0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses0;
        kv.operation_in = OP_NOOP;
        kv.key_in       = '0;
        kv.value_in     = '0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 64'(kv.ready_out),   64'd0);
        check_val("rst_succ",  64'(kv.op_succ_out), 64'd0);
        check_val("rst_value", kv.value_out,        64'd0);
        check_val("rst_busy",  64'(kv.busy_out),    64'd0);
        check_val("rst_count", 64'(kv.count_out),   64'd0);
        rst_n = 1'b1;

        run_op("read_empty", OP_READ,   32'h12, 64'h0, 1'b0);
        run_op("ups_new",    OP_UPSERT, 32'h12, 64'hDEADBEEF_00000001, 1'b0);
        run_op("read_hit",   OP_READ,   32'h12, 64'h0, 1'b0);
        run_op("ups_hit",    OP_UPSERT, 32'h12, 64'h5, 1'b0);
        run_op("read_upd",   OP_READ,   32'h12, 64'h0, 1'b0);
        run_op("ups_key0",   OP_UPSERT, 32'h0,  64'hA, 1'b0);
        run_op("read_key0",  OP_READ,   32'h0,  64'h0, 1'b0);
        run_op("del_12",     OP_DELETE, 32'h12, 64'h0, 1'b0);
        run_op("del_key0",   OP_DELETE, 32'h0,  64'h0, 1'b0);

        for (int k = 1; k <= NE; k++)
            run_op("fill", OP_UPSERT, 32'(k), 64'h100 + 64'(k), 1'b0);
        run_op("ups_full",  OP_UPSERT, 32'd5, 64'h505, 1'b0);
        run_op("del_2",     OP_DELETE, 32'd2, 64'h0,   1'b0);
        run_op("ups_freed", OP_UPSERT, 32'd5, 64'h505, 1'b0);
        run_op("read_5",    OP_READ,   32'd5, 64'h0,   1'b0);
        run_op("read_3",    OP_READ,   32'd3, 64'h0,   1'b0);
        run_op("del_miss",  OP_DELETE, 32'd9, 64'h0,   1'b0);

        // Reset in the middle of an UPSERT miss: no write, no ready pulse
        run_op("del_1", OP_DELETE, 32'd1, 64'h0, 1'b0);
        pulses0 = ready_pulses;
        @(negedge clk);
        kv.operation_in = OP_UPSERT;
        kv.key_in       = 32'h77;
        kv.value_in     = 64'h7777;
        @(posedge clk);
        #1 kv.operation_in = OP_NOOP;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_count", 64'(kv.count_out), 64'd0);
        check_val("abort_busy",  64'(kv.busy_out),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl.delete();
        repeat (3) @(negedge clk);
        check_val("abort_no_ready", 64'(ready_pulses - pulses0), 64'd0);
        run_op("read_aborted", OP_READ, 32'h77, 64'h0, 1'b0);

        // Input driven while busy must be ignored; illegal op does nothing
        run_op("ups_a",     OP_UPSERT, 32'h31, 64'h31, 1'b0);
        run_op("busy_poke", OP_READ,   32'h31, 64'h0,  1'b1);
        run_op("read_poke", OP_READ,   32'h99, 64'h0,  1'b0);
        run_op("illegal",   operation_e'(3'd5), 32'h31, 64'hBAD, 1'b0);
        run_op("read_after_illegal", OP_READ, 32'h31, 64'h0, 1'b0);

        for (int n = 0; n < 24; n++)
            run_op("rand", operation_e'($urandom_range(1, 3)), 32'($urandom_range(1, 6)),
                   {$urandom, $urandom}, 1'b0);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
